// File: rtl/tohost_monitor_pkg.sv
// Shared types and register map for the tohost completion monitor.
// FSM state encoding matches the STATUS.state field.
package tohost_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUNNING  = 2'd1,
        ST_FINISHED = 2'd2,
        ST_TIMEOUT  = 2'd3
    } state_e;

    localparam logic [15:0] OFF_STATUS  = 16'h0000;
    localparam logic [15:0] OFF_CTRL    = 16'h0004;
    localparam logic [15:0] OFF_TLIMIT  = 16'h0008;
    localparam logic [15:0] OFF_CYCLES  = 16'h000C;
    localparam logic [15:0] OFF_CH_BASE = 16'h0010;  // per channel: +0 TOHOST_ADDR, +4 RESULT, stride 8

    localparam int CTRL_ARM_BIT   = 0;
    localparam int CTRL_CLEAR_BIT = 1;

    function automatic logic [31:0] be_merge(input logic [31:0] cur,
                                             input logic [31:0] wd,
                                             input logic [3:0]  be);
        logic [31:0] r;
        r = cur;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/tohost_awq.sv
// Synchronous FIFO of snooped AW entries awaiting their W burst.
// Pushes into a full queue are refused; the caller flags the overflow.
module tohost_awq #(
    parameter int DEPTH = 4,
    parameter int W     = 40
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [PW:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic         do_push, do_pop;

    // Extra pointer bit distinguishes full from empty when indices match.
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign dout_o  = mem_q[rptr_q[PW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + {{PW{1'b0}}, 1'b1};
            if (do_pop)  rptr_d = rptr_q + {{PW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            if (!flush_i && do_push) mem_q[wptr_q[PW-1:0]] <= din_i;
        end
    end

endmodule

// File: rtl/tohost_monitor.sv
// Passive AXI write snooper that latches tohost results per channel and
// reports run completion or timeout through a small register block.
module tohost_monitor
    import tohost_monitor_pkg::*;
#(
    parameter int          NCH       = 1,
    parameter int          ADDR_W    = 32,
    parameter int          DATA_W    = 32,
    parameter int          AWQ_DEPTH = 4,
    parameter logic [15:0] REG_BASE  = 16'h1100
) (
    input  logic                ACLK,
    input  logic                ARESETN,
    input  logic                S_AWVALID,
    input  logic                S_AWREADY,
    input  logic [ADDR_W-1:0]   S_AWADDR,
    input  logic [7:0]          S_AWLEN,
    input  logic                S_WVALID,
    input  logic                S_WREADY,
    input  logic                S_WLAST,
    input  logic [DATA_W-1:0]   S_WDATA,
    input  logic [DATA_W/8-1:0] S_WSTRB,
    input  logic [15:0]         WRADDR,
    input  logic [3:0]          BYTEEN,
    input  logic                WREN,
    input  logic [31:0]         WDATA,
    input  logic [15:0]         RDADDR,
    input  logic                RDEN,
    output logic [31:0]         RDATA,
    output logic                DONE,
    output logic                PASS
);

    state_e      state_q, state_d;
    logic [31:0] tlimit_q, tlimit_d;
    logic [31:0] cycles_q, cycles_d;
    logic [31:0] tohost_q [NCH];
    logic [31:0] tohost_d [NCH];
    logic [31:0] result_q [NCH];
    logic [31:0] result_d [NCH];
    logic [NCH-1:0] done_q, done_d;
    logic        ovf_q, ovf_d;
    logic [31:0] rdata_q, rdata_d;

    // ---------------- register write decode ----------------
    logic [15:0] woff, roff;
    logic        ctrl_wr, arm, clr, flush;

    assign woff    = WRADDR - REG_BASE;
    assign roff    = RDADDR - REG_BASE;
    assign ctrl_wr = WREN && (woff == OFF_CTRL) && BYTEEN[0];
    assign arm     = ctrl_wr & WDATA[CTRL_ARM_BIT];
    assign clr     = ctrl_wr & WDATA[CTRL_CLEAR_BIT];
    assign flush   = arm | clr;

    // ---------------- AXI snoop ----------------
    logic                  run, aw_hs, w_hs, beat0, w_end;
    logic                  pair_direct, buf_resolve, aw_consumed, awq_req;
    logic                  q_push, q_pop, q_full, q_empty;
    logic [ADDR_W+7:0]     q_head;
    logic                  in_burst_q, in_burst_d;
    logic                  buf_vld_q, buf_vld_d, buf_last_q, buf_last_d, buf_load;
    logic [DATA_W-1:0]     buf_data_q, buf_data_d;
    logic [DATA_W/8-1:0]   buf_strb_q, buf_strb_d;

    // Snooping is frozen on the ARM/CLEAR cycle so the flush cannot race a push.
    assign run   = (state_q == ST_RUNNING) & ~flush;
    assign aw_hs = run & S_AWVALID & S_AWREADY;
    assign w_hs  = run & S_WVALID & S_WREADY;
    assign beat0 = w_hs & ~in_burst_q;
    assign w_end = w_hs & S_WLAST;

    assign pair_direct = beat0 & q_empty & ~buf_vld_q & aw_hs;
    assign buf_resolve = buf_vld_q & aw_hs;
    // An AW whose burst has already ended (or ends now) never enters the queue.
    assign aw_consumed = (pair_direct & S_WLAST) | (buf_resolve & (buf_last_q | w_end));
    assign awq_req     = aw_hs & ~aw_consumed;
    assign q_push      = awq_req & ~q_full;
    assign q_pop       = w_end & ~buf_vld_q & ~q_empty;
    assign buf_load    = beat0 & q_empty &
                         ((~buf_vld_q & ~aw_hs) | (buf_resolve & buf_last_q));

    tohost_awq #(
        .DEPTH (AWQ_DEPTH),
        .W     (ADDR_W + 8)
    ) u_awq (
        .clk_i   (ACLK),
        .rst_ni  (ARESETN),
        .flush_i (flush),
        .push_i  (q_push),
        .pop_i   (q_pop),
        .din_i   ({S_AWADDR, S_AWLEN}),
        .dout_o  (q_head),
        .full_o  (q_full),
        .empty_o (q_empty)
    );

    always_comb begin
        in_burst_d = in_burst_q;
        buf_vld_d  = buf_vld_q;
        buf_last_d = buf_last_q;
        buf_data_d = buf_data_q;
        buf_strb_d = buf_strb_q;
        if (w_hs) in_burst_d = ~S_WLAST;
        if (buf_resolve)          buf_vld_d  = 1'b0;
        else if (buf_vld_q && w_end) buf_last_d = 1'b1;
        if (buf_load) begin
            buf_vld_d  = 1'b1;
            buf_last_d = S_WLAST;
            buf_data_d = S_WDATA;
            buf_strb_d = S_WSTRB;
        end
        if (flush) begin
            in_burst_d = 1'b0;
            buf_vld_d  = 1'b0;
            buf_last_d = 1'b0;
        end
    end

    // ---------------- beat-0 evaluation ----------------
    logic                ev_vld, ev_ok;
    logic [ADDR_W-1:0]   ev_addr;
    logic [DATA_W-1:0]   ev_data;
    logic [DATA_W/8-1:0] ev_strb;
    logic [31:0]         ev_word;
    logic [3:0]          ev_lstrb;
    logic [NCH-1:0]      match;

    always_comb begin
        ev_vld  = 1'b0;
        ev_addr = q_head[ADDR_W+7:8];
        ev_data = S_WDATA;
        ev_strb = S_WSTRB;
        if (buf_resolve) begin
            ev_vld  = 1'b1;
            ev_addr = S_AWADDR;
            ev_data = buf_data_q;
            ev_strb = buf_strb_q;
        end else if (pair_direct) begin
            ev_vld  = 1'b1;
            ev_addr = S_AWADDR;
        end else if (beat0 && !q_empty && !buf_vld_q) begin
            ev_vld  = 1'b1;
        end
    end

    generate
        if (DATA_W == 64) begin : g_lane64
            assign ev_word  = ev_addr[2] ? ev_data[63:32] : ev_data[31:0];
            assign ev_lstrb = ev_addr[2] ? ev_strb[7:4]   : ev_strb[3:0];
        end else begin : g_lane32
            assign ev_word  = ev_data[31:0];
            assign ev_lstrb = ev_strb[3:0];
        end
    endgenerate

    assign ev_ok = ev_vld & (ev_lstrb == 4'hF) & ev_word[0];

    always_comb begin
        logic [ADDR_W-1:0] th;
        for (int i = 0; i < NCH; i++) begin
            th       = ADDR_W'(tohost_q[i]);
            match[i] = (th[ADDR_W-1:2] == ev_addr[ADDR_W-1:2]);
        end
    end

    logic unused_bits;
    assign unused_bits = ^{q_head[7:0], ev_addr[1:0]};

    // ---------------- registers and run state ----------------
    always_comb begin
        tlimit_d = tlimit_q;
        tohost_d = tohost_q;
        result_d = result_q;
        done_d   = done_q;
        ovf_d    = ovf_q;
        if (WREN && woff == OFF_TLIMIT) tlimit_d = be_merge(tlimit_q, WDATA, BYTEEN);
        for (int i = 0; i < NCH; i++) begin
            if (WREN && woff == OFF_CH_BASE + 16'(8*i))
                tohost_d[i] = be_merge(tohost_q[i], WDATA, BYTEEN);
            if (ev_ok && match[i] && !done_q[i]) begin
                result_d[i] = ev_word;
                done_d[i]   = 1'b1;
            end
        end
        if (awq_req && q_full) ovf_d = 1'b1;
        if (arm) begin
            for (int i = 0; i < NCH; i++) result_d[i] = '0;
            done_d = '0;
            ovf_d  = 1'b0;
        end
    end

    always_comb begin
        state_d  = state_q;
        cycles_d = cycles_q;
        if (state_q == ST_RUNNING && cycles_q != 32'hFFFF_FFFF) cycles_d = cycles_q + 32'd1;
        if (arm) begin
            state_d  = ST_RUNNING;
            cycles_d = '0;
        end else begin
            case (state_q)
                // Completion is tested on the next DONE vector so a last report
                // landing on the timeout cycle still counts as finished.
                ST_RUNNING: begin
                    if (&done_d)                                     state_d = ST_FINISHED;
                    else if (tlimit_q != '0 && cycles_d == tlimit_q) state_d = ST_TIMEOUT;
                end
                ST_FINISHED, ST_TIMEOUT: if (clr) state_d = ST_IDLE;
                default: ;
            endcase
        end
    end

    // ---------------- readback ----------------
    logic [7:0] done8;
    logic       all_one;

    assign done8 = 8'(done_q);

    always_comb begin
        rdata_d = rdata_q;
        if (RDEN) begin
            rdata_d = '0;
            if (roff == OFF_STATUS) rdata_d = {ovf_q, 21'd0, state_q, done8};
            if (roff == OFF_TLIMIT) rdata_d = tlimit_q;
            if (roff == OFF_CYCLES) rdata_d = cycles_q;
            for (int i = 0; i < NCH; i++) begin
                if (roff == OFF_CH_BASE + 16'(8*i))     rdata_d = tohost_q[i];
                if (roff == OFF_CH_BASE + 16'(8*i + 4)) rdata_d = result_q[i];
            end
        end
    end

    always_comb begin
        all_one = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            if (result_q[i] != 32'd1) all_one = 1'b0;
        end
    end

    assign RDATA = rdata_q;
    assign DONE  = (state_q == ST_FINISHED) || (state_q == ST_TIMEOUT);
    assign PASS  = (state_q == ST_FINISHED) && all_one;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q    <= ST_IDLE;
            tlimit_q   <= '0;
            cycles_q   <= '0;
            done_q     <= '0;
            ovf_q      <= 1'b0;
            rdata_q    <= '0;
            in_burst_q <= 1'b0;
            buf_vld_q  <= 1'b0;
            buf_last_q <= 1'b0;
            buf_data_q <= '0;
            buf_strb_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                tohost_q[i] <= '0;
                result_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            tlimit_q   <= tlimit_d;
            cycles_q   <= cycles_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            rdata_q    <= rdata_d;
            in_burst_q <= in_burst_d;
            buf_vld_q  <= buf_vld_d;
            buf_last_q <= buf_last_d;
            buf_data_q <= buf_data_d;
            buf_strb_q <= buf_strb_d;
            tohost_q   <= tohost_d;
            result_q   <= result_d;
        end
    end

endmodule

// File: tb/tb_tohost_monitor.sv
// Directed bench for tohost_monitor: two channels on a 64-bit snooped bus.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_tohost_monitor;

    localparam logic [15:0] B = 16'h1100;
    localparam logic [15:0] R_STATUS = B + 16'h00;
    localparam logic [15:0] R_CTRL   = B + 16'h04;
    localparam logic [15:0] R_TLIM   = B + 16'h08;
    localparam logic [15:0] R_CYC    = B + 16'h0C;
    localparam logic [15:0] R_TH0    = B + 16'h10;
    localparam logic [15:0] R_RES0   = B + 16'h14;
    localparam logic [15:0] R_TH1    = B + 16'h18;
    localparam logic [15:0] R_RES1   = B + 16'h1C;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic        S_AWVALID, S_AWREADY, S_WVALID, S_WREADY, S_WLAST;
    logic [31:0] S_AWADDR;
    logic [7:0]  S_AWLEN;
    logic [63:0] S_WDATA;
    logic [7:0]  S_WSTRB;
    logic [15:0] WRADDR, RDADDR;
    logic [3:0]  BYTEEN;
    logic        WREN, RDEN;
    logic [31:0] WDATA, RDATA;
    logic        DONE, PASS;

    int total = 0;
    int bad   = 0;
    int unsigned cyc = 0;
    int unsigned c_arm;

    tohost_monitor #(
        .NCH(2), .ADDR_W(32), .DATA_W(64), .AWQ_DEPTH(4), .REG_BASE(16'h1100)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY), .S_AWADDR(S_AWADDR), .S_AWLEN(S_AWLEN),
        .S_WVALID(S_WVALID), .S_WREADY(S_WREADY), .S_WLAST(S_WLAST),
        .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB),
        .WRADDR(WRADDR), .BYTEEN(BYTEEN), .WREN(WREN), .WDATA(WDATA),
        .RDADDR(RDADDR), .RDEN(RDEN), .RDATA(RDATA),
        .DONE(DONE), .PASS(PASS)
    );

    always #5 ACLK = ~ACLK;
    always @(posedge ACLK) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic regwr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge ACLK);
        WRADDR = a; WDATA = d; BYTEEN = be; WREN = 1'b1;
        @(negedge ACLK);
        WREN = 1'b0;
    endtask

    task automatic chk_reg(input string tag, input logic [15:0] a, input logic [31:0] exp);
        @(negedge ACLK);
        RDADDR = a; RDEN = 1'b1;
        @(negedge ACLK);
        RDEN = 1'b0;
        chk(tag, RDATA, exp);
    endtask

    task automatic aw_only(input logic [31:0] a, input logic [7:0] len);
        @(negedge ACLK);
        S_AWVALID = 1'b1; S_AWADDR = a; S_AWLEN = len;
        @(negedge ACLK);
        S_AWVALID = 1'b0;
    endtask

    task automatic w_beat(input logic [63:0] d, input logic [7:0] s, input logic last);
        @(negedge ACLK);
        S_WVALID = 1'b1; S_WDATA = d; S_WSTRB = s; S_WLAST = last;
        @(negedge ACLK);
        S_WVALID = 1'b0; S_WLAST = 1'b0;
    endtask

    task automatic aw_w(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
        @(negedge ACLK);
        S_AWVALID = 1'b1; S_AWADDR = a; S_AWLEN = 8'd0;
        S_WVALID = 1'b1; S_WDATA = d; S_WSTRB = s; S_WLAST = 1'b1;
        @(negedge ACLK);
        S_AWVALID = 1'b0; S_WVALID = 1'b0; S_WLAST = 1'b0;
    endtask

    initial begin
        ARESETN = 1'b0;
        S_AWVALID = 1'b0; S_AWREADY = 1'b1; S_AWADDR = '0; S_AWLEN = '0;
        S_WVALID = 1'b0; S_WREADY = 1'b1; S_WLAST = 1'b0; S_WDATA = '0; S_WSTRB = '0;
        WRADDR = '0; BYTEEN = '0; WREN = 1'b0; WDATA = '0;
        RDADDR = '0; RDEN = 1'b0;

        // reset state
        repeat (3) @(negedge ACLK);
        chk("rst_done", 32'(DONE), 32'd0);
        chk("rst_pass", 32'(PASS), 32'd0);
        chk("rst_rdata", RDATA, 32'd0);
        ARESETN = 1'b1;
        chk_reg("rst_status", R_STATUS, 32'h0000_0000);
        chk_reg("rst_cycles", R_CYC, 32'h0000_0000);

        // single passing write, AW and W in the same cycle; both channels watch one address
        regwr(R_TH0, 32'h2000_1000, 4'hF);
        regwr(R_TH1, 32'h2000_1000, 4'hF);
        chk_reg("th0_rb", R_TH0, 32'h2000_1000);
        regwr(R_CTRL, 32'h1, 4'hF);
        chk_reg("a_running", R_STATUS, 32'h0000_0100);
        aw_w(32'h2000_1000, 64'h0000_0007_0000_0001, 8'h0F);
        chk("a_done", 32'(DONE), 32'd1);
        chk("a_pass", 32'(PASS), 32'd1);
        chk_reg("a_res0", R_RES0, 32'h1);
        chk_reg("a_res1", R_RES1, 32'h1);
        chk_reg("a_status", R_STATUS, 32'h0000_0203);

        // failing code, first-latch-wins, multi-beat burst only compares beat 0
        regwr(R_CTRL, 32'h2, 4'hF);
        chk_reg("b_cleared", R_STATUS, 32'h0000_0003);
        regwr(R_TH1, 32'h2000_2000, 4'hF);
        regwr(R_CTRL, 32'h1, 4'hF);
        chk_reg("b_arm_res0", R_RES0, 32'h0);
        aw_only(32'h2000_1000, 8'd0);
        w_beat(64'h0000_0000_0000_000B, 8'h0F, 1'b1);
        chk_reg("b_res0", R_RES0, 32'h0000_000B);
        chk_reg("b_status1", R_STATUS, 32'h0000_0101);
        aw_only(32'h2000_2000, 8'd1);
        w_beat(64'h0000_0000_0000_0002, 8'h0F, 1'b0);
        w_beat(64'h0000_0000_0000_0001, 8'h0F, 1'b1);
        chk_reg("b_beat1_ign", R_RES1, 32'h0);
        aw_w(32'h2000_1000, 64'h0000_0000_0000_0001, 8'h0F);
        chk_reg("b_first_wins", R_RES0, 32'h0000_000B);
        aw_w(32'h2000_2000, 64'h0000_0000_0000_0001, 8'h0F);
        chk("b_done", 32'(DONE), 32'd1);
        chk("b_pass", 32'(PASS), 32'd0);
        chk_reg("b_status2", R_STATUS, 32'h0000_0203);
        chk_reg("b_res1", R_RES1, 32'h1);

        // timeout with only channel 0 reporting; limit written through byte 0 only
        regwr(R_CTRL, 32'h2, 4'hF);
        regwr(R_TH1, 32'h2000_3000, 4'hF);
        regwr(R_TLIM, 32'hFFFF_FF64, 4'b0001);
        chk_reg("c_tlim", R_TLIM, 32'h0000_0064);
        regwr(R_CTRL, 32'h1, 4'hF);
        c_arm = cyc;
        aw_w(32'h2000_1000, 64'h0000_0000_0000_0001, 8'h0F);
        for (int k = 0; k < 300 && !DONE; k++) @(negedge ACLK);
        chk("c_latency", cyc - c_arm, 32'd100);
        chk("c_pass", 32'(PASS), 32'd0);
        chk_reg("c_status", R_STATUS, 32'h0000_0301);
        chk_reg("c_cycles", R_CYC, 32'd100);
        regwr(R_TLIM, 32'h0, 4'hF);

        // W ahead of AW by 3 cycles, upper 32-bit lane; partial lane strobe ignored
        regwr(R_CTRL, 32'h2, 4'hF);
        regwr(R_TH0, 32'h2000_1004, 4'hF);
        regwr(R_TH1, 32'h2000_1004, 4'hF);
        regwr(R_CTRL, 32'h1, 4'hF);
        aw_w(32'h2000_1004, 64'h0000_0003_0000_0000, 8'h70);
        chk_reg("d_partial", R_STATUS, 32'h0000_0100);
        w_beat(64'h0000_0005_0000_0001, 8'hF0, 1'b1);
        @(negedge ACLK);
        chk("d_waiting", 32'(DONE), 32'd0);
        aw_only(32'h2000_1004, 8'd0);
        chk("d_done", 32'(DONE), 32'd1);
        chk("d_pass", 32'(PASS), 32'd0);
        chk_reg("d_res0", R_RES0, 32'h5);
        chk_reg("d_res1", R_RES1, 32'h5);

        // queue overflow, then CLEAR+ARM flushes the stale entries
        regwr(R_CTRL, 32'h2, 4'hF);
        regwr(R_TH0, 32'h2000_1000, 4'hF);
        regwr(R_TH1, 32'h2000_1000, 4'hF);
        regwr(R_CTRL, 32'h1, 4'hF);
        @(negedge ACLK);
        S_AWVALID = 1'b1; S_AWADDR = 32'h2000_1000; S_AWLEN = 8'd0;
        repeat (5) @(negedge ACLK);
        S_AWVALID = 1'b0;
        chk_reg("e_ovf", R_STATUS, 32'h8000_0100);
        regwr(R_CTRL, 32'h3, 4'hF);
        chk_reg("e_rearm", R_STATUS, 32'h0000_0100);
        w_beat(64'h0000_0000_0000_0001, 8'h0F, 1'b1);
        chk_reg("e_flushed", R_STATUS, 32'h0000_0100);
        aw_only(32'h2000_5000, 8'd0);
        chk_reg("e_nomatch", R_RES0, 32'h0);
        aw_w(32'h2000_1000, 64'h0000_0000_0000_0001, 8'h0F);
        chk_reg("e_status", R_STATUS, 32'h0000_0203);
        chk("e_pass", 32'(PASS), 32'd1);

        // reset mid-run abandons a pending AW
        regwr(R_CTRL, 32'h2, 4'hF);
        regwr(R_CTRL, 32'h1, 4'hF);
        aw_only(32'h2000_1000, 8'd0);
        @(negedge ACLK);
        ARESETN = 1'b0;
        @(negedge ACLK);
        chk("r_done", 32'(DONE), 32'd0);
        ARESETN = 1'b1;
        chk_reg("r_status", R_STATUS, 32'h0);
        regwr(R_TH0, 32'h2000_1000, 4'hF);
        regwr(R_TH1, 32'h2000_1000, 4'hF);
        regwr(R_CTRL, 32'h1, 4'hF);
        w_beat(64'h0000_0000_0000_0001, 8'h0F, 1'b1);
        chk_reg("r_no_stale", R_STATUS, 32'h0000_0100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
